// File: rtl/hack_mem_pkg.sv
// Shared types and constants for the parametrised Hack word RAM and its clear sequencer.
package hack_mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    localparam int LAT_COMB = 0;
    localparam int LAT_REG  = 1;

    function automatic int depth_of(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

endpackage

// File: rtl/hack_ram_clear_seq.sv
// Post-reset clear sequencer: sweeps every address once, writing zero, and flags busy meanwhile.
module hack_ram_clear_seq
    import hack_mem_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    clr_state_e        state_r;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic              busy_r;

    // Sweep state machine; busy is registered alongside the state so it never glitches.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clr_ptr_r <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state_r <= CLEAR;
                busy_r  <= 1'b1;
            end else begin
                state_r <= READY;
                busy_r  <= 1'b0;
            end
        end else begin
            case (state_r)
                CLEAR: begin
                    clr_ptr_r <= clr_ptr_r + ADDR_W'(1);
                    if (clr_ptr_r == LAST_ADDR) begin
                        state_r <= READY;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                READY: begin
                    state_r <= READY;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= READY;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state_r == CLEAR);
    assign clr_addr = clr_ptr_r;
    assign busy     = busy_r;

endmodule

// File: rtl/hack_ram_ctl.sv
// Parametrised single-port word RAM with selectable read latency and optional zero-fill after reset.
module hack_ram_ctl
    import hack_mem_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int ADDR_W         = 12,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              busy_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [WIDTH-1:0]  wr_data_s;

    hack_ram_clear_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s),
        .busy     (busy_s)
    );

    // Write port arbitration: the clear sweep wins, user writes are dropped while busy, nothing is written on a reset edge.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = address;
        wr_data_s = in;
        if (!reset_n) begin
            wr_en_s = 1'b0;
        end else if (clr_we_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_addr_s;
            wr_data_s = '0;
        end else if (load && !busy_s) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Storage array; deliberately has no reset so it maps onto RAM macros.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    generate
        if (READ_LAT == LAT_COMB) begin : g_read_comb
            logic [WIDTH-1:0] rdata_s;

            // Asynchronous read, forced to zero while the sweep owns the array.
            always_comb begin
                rdata_s = '0;
                if (busy_s) begin
                    rdata_s = '0;
                end else begin
                    rdata_s = mem_r[address];
                end
            end

            assign out = rdata_s;
        end else begin : g_read_reg
            logic [WIDTH-1:0] rdata_r;

            // Read-first registered read: samples the array before this edge's write lands.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    rdata_r <= '0;
                end else if (busy_s) begin
                    rdata_r <= '0;
                end else begin
                    rdata_r <= mem_r[address];
                end
            end

            assign out = rdata_r;
        end
    endgenerate

    assign busy = busy_s;

endmodule

// File: tb/tb_hack_ram_ctl.sv
// Randomised scoreboard bench: three RAM configurations share one stimulus stream against a behavioural model.
module tb_hack_ram_ctl;

    localparam int W  = 16;
    localparam int AW = 3;
    localparam int D  = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic [AW-1:0] address = '0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  out0, out1, out2;
    logic          busy0, busy1, busy2;

    always #5 clock = ~clock;

    // inst0: registered read + clear, inst1: comb read + clear, inst2: registered read, no clear
    hack_ram_ctl #(.WIDTH(W), .ADDR_W(AW), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .in(din), .address(address), .load(load), .out(out0), .busy(busy0));
    hack_ram_ctl #(.WIDTH(W), .ADDR_W(AW), .READ_LAT(0), .CLEAR_ON_RESET(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .in(din), .address(address), .load(load), .out(out1), .busy(busy1));
    hack_ram_ctl #(.WIDTH(W), .ADDR_W(AW), .READ_LAT(1), .CLEAR_ON_RESET(0)) dut2 (
        .clock(clock), .reset_n(reset_n), .in(din), .address(address), .load(load), .out(out2), .busy(busy2));

    typedef struct packed {
        logic [2:0][W-1:0] out;
        logic [2:0]        known;
        logic [2:0]        busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: words, a remaining-clear-cycles count and the last registered read value
    logic [W-1:0] m_mem [3][D];
    bit           m_known [3][D];
    int           m_busy [3];
    logic [W-1:0] m_rd [3];
    bit           m_rd_known [3];
    bit           started = 1'b0;

    function automatic bit is_reg(input int i);
        return i != 1;
    endfunction

    function automatic bit clears(input int i);
        return i != 2;
    endfunction

    task automatic model_step(input logic rn, input logic ld, input logic [AW-1:0] ad, input logic [W-1:0] d);
        for (int i = 0; i < 3; i++) begin
            if (!rn) begin
                m_busy[i]     = clears(i) ? D : 0;
                m_rd[i]       = '0;
                m_rd_known[i] = 1'b1;
            end else if (m_busy[i] > 0) begin
                m_mem[i][D - m_busy[i]]   = '0;
                m_known[i][D - m_busy[i]] = 1'b1;
                m_busy[i]                 = m_busy[i] - 1;
                m_rd[i]                   = '0;
                m_rd_known[i]             = 1'b1;
            end else begin
                m_rd[i]       = m_mem[i][ad];
                m_rd_known[i] = m_known[i][ad];
                if (ld) begin
                    m_mem[i][ad]   = d;
                    m_known[i][ad] = 1'b1;
                end
            end
        end
        started = 1'b1;
    endtask

    task automatic push_expect();
        exp_t e;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            e.busy[i] = (m_busy[i] > 0);
            if (is_reg(i)) begin
                e.out[i]   = m_rd[i];
                e.known[i] = m_rd_known[i];
            end else if (m_busy[i] > 0) begin
                e.out[i]   = '0;
                e.known[i] = 1'b1;
            end else begin
                e.out[i]   = m_mem[i][address];
                e.known[i] = m_known[i][address];
            end
        end
        sb_q.push_back(e);
    endtask

    // Drive one cycle's inputs, record what the outputs must show before the next edge, then take the edge
    task automatic tick(input logic rn, input logic ld, input logic [AW-1:0] ad, input logic [W-1:0] d);
        reset_n = rn;
        load    = ld;
        address = ad;
        din     = d;
        if (started) push_expect();
        @(posedge clock);
        model_step(rn, ld, ad, d);
        #1;
    endtask

    logic [2:0][W-1:0] act_out;
    logic [2:0]        act_busy;
    assign act_out  = {out2, out1, out0};
    assign act_busy = {busy2, busy1, busy0};

    exp_t mon_e;
    // Monitor: every cycle the DUTs present outputs; pop one expectation and compare mid-cycle
    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (act_busy[i] !== mon_e.busy[i]) begin
                    n_err++;
                    $display("FAIL busy inst%0d t=%0t: got %b expected %b", i, $time, act_busy[i], mon_e.busy[i]);
                end
                if (mon_e.known[i]) begin
                    n_vec++;
                    if (act_out[i] !== mon_e.out[i]) begin
                        n_err++;
                        $display("FAIL out inst%0d t=%0t: got %h expected %h", i, $time, act_out[i], mon_e.out[i]);
                    end
                end
            end
        end
    end

    initial begin
        // Reset two cycles, let the first sweep finish, then fill every word with 0xFFFF
        tick(1'b0, 1'b0, 3'd0, 16'h0000);
        tick(1'b0, 1'b0, 3'd0, 16'h0000);
        for (int k = 0; k < D; k++) tick(1'b1, 1'b0, AW'(k), 16'h0000);
        for (int k = 0; k < D; k++) tick(1'b1, 1'b1, AW'(k), 16'hFFFF);

        // Sweep must zero the 0xFFFF fill; a write to addr 2 while busy must be dropped
        tick(1'b0, 1'b0, 3'd0, 16'h0000);
        tick(1'b0, 1'b0, 3'd0, 16'h0000);
        for (int k = 0; k < D; k++) begin
            if (k == 3) tick(1'b1, 1'b1, 3'd2, 16'h1234);
            else        tick(1'b1, 1'b0, AW'(7 - k), 16'h0000);
        end
        for (int k = 0; k < D; k++) tick(1'b1, 1'b0, AW'(k), 16'h0000);
        tick(1'b1, 1'b0, 3'd2, 16'h0000);

        // Same-edge write and read of addr 5: old data first, new data on the following read
        tick(1'b1, 1'b1, 3'd5, 16'hBEEF);
        tick(1'b1, 1'b0, 3'd5, 16'h0000);
        tick(1'b1, 1'b0, 3'd0, 16'h0000);

        // Reset re-asserted on the third clear cycle restarts the full sweep
        tick(1'b1, 1'b1, 3'd6, 16'h00AA);
        tick(1'b0, 1'b0, 3'd6, 16'h0000);
        tick(1'b1, 1'b0, 3'd6, 16'h0000);
        tick(1'b1, 1'b0, 3'd6, 16'h0000);
        tick(1'b0, 1'b0, 3'd6, 16'h0000);
        for (int k = 0; k < D + 2; k++) tick(1'b1, 1'b0, 3'd6, 16'h0000);

        // Combinational read sees the new word straight after the write edge and follows address changes
        tick(1'b1, 1'b1, 3'd7, 16'h7FFF);
        tick(1'b1, 1'b0, 3'd7, 16'h0000);
        tick(1'b1, 1'b0, 3'd0, 16'h0000);

        // Without clear-on-reset the word survives a one-cycle reset pulse
        tick(1'b1, 1'b1, 3'd1, 16'h0042);
        tick(1'b0, 1'b0, 3'd1, 16'h0000);
        tick(1'b1, 1'b0, 3'd1, 16'h0000);
        tick(1'b1, 1'b0, 3'd1, 16'h0000);

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            tick(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, D - 1)), W'($urandom));
        end
        tick(1'b1, 1'b0, 3'd0, 16'h0000);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clock);
        if (sb_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
